mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised successor to the pipeline memory stage. It sits between the execute and writeback stages and accepts one instruction at a time through a valid/ready handshake. Loads and stores run on a request/grant/response memory port, with byte, halfword, word and (when XLEN=64) doubleword accesses, byte enables, load sign/zero extension and misalignment detection. Unlike the fixed single-cycle stage, it stalls upstream while a memory transaction is outstanding.

## Interface
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: address and PC width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_alu_result  in  XLEN  ALU result or effective address.
- in_store_data  in  XLEN  rs2 value for stores.
- in_rd  in  5  destination register.
- in_rd_wen  in  1  register write enable.
- in_mem_we / in_mem_re  in  1 each  store / load; both high is treated as a store.
- in_funct3  in  3  access size and signedness.
- in_wb_sel  in  3  000 = ALU result, 100 = load data, else zero.
- in_pc  in  ADDR_W  instruction PC.
- mem_req  out  1  memory request.
- mem_gnt  in  1  request accepted.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W  address, aligned down to XLEN/8 bytes.
- mem_wdata  out  XLEN  write data, lane-replicated.
- mem_be  out  XLEN/8  byte enables.
- mem_rvalid  in  1  read response valid.
- mem_rdata  in  XLEN  read data, full aligned word.
- wb_valid  out  1  one-cycle result pulse to writeback.
- wb_rd  out  5  destination register.
- wb_rd_wen  out  1  write enable; forced 0 when misaligned.
- wb_data  out  XLEN  writeback data.
- wb_pc  out  ADDR_W  PC.
- wb_misalign  out  1  address misaligned for the access size.

## Operation
- FSM states:
  - IDLE: `in_ready = 1`. On `in_valid`, capture all `in_*` into a register.
    - Non-memory op or misaligned access goes to DONE.
    - Aligned load or store goes to REQ.
  - REQ: hold `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_be` stable until `mem_gnt`.
    - Store with `mem_gnt` goes to DONE.
    - Load with `mem_gnt` goes to RSP.
  - RSP: wait for `mem_rvalid`. Select the byte lane by address low bits, extend the data, then go to DONE.
  - DONE: pulse `wb_valid` for one cycle, then return to IDLE. `in_ready = 0`.
- funct3 encoding:
  - 000 = byte, 001 = half, 010 = word, 011 = double.
  - Bit 2 selects zero extension for loads.
  - 011 and 110 are legal only when XLEN=64. Otherwise they are treated as word.
- Misaligned when `addr % size != 0`. Then:
  - no memory request is issued;
  - `wb_misalign = 1`, `wb_rd_wen = 0`, `wb_data = 0`.
- Store byte enables: contiguous ones for the size, shifted by `addr[log2(XLEN/8)-1:0]`. Write data is the low bytes of `in_store_data`, replicated across lanes.
- Stores produce `wb_valid` with `wb_rd_wen` taken from the captured value (normally 0).
- Reset, including mid-transaction: FSM returns to IDLE and every output is 0 except `in_ready`, which is 1. A later stray `mem_rvalid` is ignored.
- `mem_gnt` or `mem_rvalid` arriving outside REQ/RSP is ignored.

## Timing
- Non-memory op: accepted at edge N, `wb_valid` high during cycle N+1.
- Store with `mem_gnt` in the first REQ cycle: `wb_valid` two cycles after acceptance.
- Load with `mem_gnt` and `mem_rvalid` each one cycle late: `wb_valid` four cycles after acceptance.
- `mem_rvalid` may arrive zero or more cycles after the grant cycle, but never in the grant cycle itself.
- All `wb_*` and `mem_*` outputs are driven from registers.
- Throughput: at most one instruction per two cycles.

## Structure
- Shared package `lsu_pkg`:
  - funct3 size/sign constants;
  - wb_sel encodings `WB_ALU = 3'b000`, `WB_MEM = 3'b100`;
  - FSM state enum.
- Sub-module `lsu_align`, purely combinational:
  - store path: size + address offset → `be`, `wdata`, `misalign`;
  - load path: `rdata` + offset + funct3 → extended load data.

## Test plan
- ALU op, `in_alu_result = 0x1234`, `wb_sel = 000`: `wb_valid` next cycle, `wb_data = 0x1234`, no `mem_req`.
- LB at `0x1003`, `mem_rdata = 0x80FFFFFF`: `mem_addr = 0x1000`, `wb_data = 0xFFFFFF80`. The LBU variant gives `0x00000080`.
- SH at `0x2002`, `store_data = 0xABCD`: `mem_be = 1100`, `mem_wdata = 0xABCDABCD`. `mem_req` is held through 3 cycles with `mem_gnt` low.
- LW at `0x3001`: no `mem_req`, `wb_misalign = 1`, `wb_rd_wen = 0`, `wb_data = 0`.
- `rst` asserted in RSP, then `mem_rvalid` arrives: outputs are 0, `in_ready = 1`, no `wb_valid`.
- XLEN=64, LD at `0x8`, `mem_rdata = 0xDEADBEEF_01234567`: `mem_be = 0xFF`, `wb_data` equals `mem_rdata`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory stage: access sizes, writeback
// select encodings and the FSM state type.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int F3_ZEXT_BIT = 2;

   localparam logic [2:0] WB_ALU = 3'b000;
   localparam logic [2:0] WB_MEM = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RSP  = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   // Doubleword encodings fall back to word on a 32-bit datapath.
   function automatic logic [1:0] eff_size(input logic [2:0] funct3, input int xlen);
      logic [1:0] sz;
      sz = funct3[1:0];
      if (sz == SZ_D && xlen != 64) sz = SZ_W;
      return sz;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the memory stage: store enables/replication and
// misalignment on one side, load lane select and extension on the other.
module lsu_align import lsu_pkg::*; #(
   parameter  int XLEN  = 32,
   localparam int NB    = XLEN / 8,
   localparam int OFF_W = $clog2(XLEN / 8)
) (
   input  logic [1:0]       st_size,
   input  logic [OFF_W-1:0] st_off,
   input  logic [XLEN-1:0]  st_data,
   output logic [NB-1:0]    be,
   output logic [XLEN-1:0]  wdata,
   output logic             misalign,
   input  logic [2:0]       ld_funct3,
   input  logic [OFF_W-1:0] ld_off,
   input  logic [XLEN-1:0]  rdata,
   output logic [XLEN-1:0]  ld_data
);

   logic [OFF_W-1:0] st_mask;
   logic [NB-1:0]    be_base;
   logic [1:0]       ld_size;
   logic [XLEN-1:0]  ld_shift;
   logic [XLEN-1:0]  ld_mask;
   logic             ld_sign;

   always_comb begin
      st_mask = '0;
      be_base = '0;
      wdata   = '0;
      case (st_size)
         SZ_B: begin
            st_mask = '0;
            be_base = NB'(8'h01);
            wdata   = {NB{st_data[7:0]}};
         end
         SZ_H: begin
            st_mask = OFF_W'(1);
            be_base = NB'(8'h03);
            wdata   = {(NB/2){st_data[15:0]}};
         end
         SZ_W: begin
            st_mask = OFF_W'(3);
            be_base = NB'(8'h0F);
            wdata   = {(NB/4){st_data[31:0]}};
         end
         default: begin
            st_mask = OFF_W'(7);
            be_base = NB'(8'hFF);
            wdata   = st_data;
         end
      endcase
      misalign = |(st_off & st_mask);
      be       = be_base << st_off;
   end

   always_comb begin
      ld_size  = eff_size(ld_funct3, XLEN);
      ld_shift = rdata >> {ld_off, 3'b000};
      ld_mask  = '1;
      ld_sign  = 1'b0;
      case (ld_size)
         SZ_B:    begin ld_mask = XLEN'(8'hFF);         ld_sign = ld_shift[7];      end
         SZ_H:    begin ld_mask = XLEN'(16'hFFFF);      ld_sign = ld_shift[15];     end
         SZ_W:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = ld_shift[31];     end
         default: begin ld_mask = '1;                   ld_sign = ld_shift[XLEN-1]; end
      endcase
      ld_sign = ld_sign & ~ld_funct3[F3_ZEXT_BIT];
      ld_data = (ld_shift & ld_mask) | (ld_sign ? ~ld_mask : '0);
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Multi-cycle memory stage: one instruction at a time, request/grant/response
// memory port, registered writeback pulse.
//
// state  | meaning
// IDLE   | ready for a new instruction
// REQ    | memory request held until granted
// RSP    | load granted, waiting for read data
// DONE   | wb_valid pulse, upstream stalled
module mem_stage_lsu import lsu_pkg::*; #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_alu_result,
   input  logic [XLEN-1:0]     in_store_data,
   input  logic [4:0]          in_rd,
   input  logic                in_rd_wen,
   input  logic                in_mem_we,
   input  logic                in_mem_re,
   input  logic [2:0]          in_funct3,
   input  logic [2:0]          in_wb_sel,
   input  logic [ADDR_W-1:0]   in_pc,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_be,
   input  logic                mem_rvalid,
   input  logic [XLEN-1:0]     mem_rdata,
   output logic                wb_valid,
   output logic [4:0]          wb_rd,
   output logic                wb_rd_wen,
   output logic [XLEN-1:0]     wb_data,
   output logic [ADDR_W-1:0]   wb_pc,
   output logic                wb_misalign
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   lsu_state_e        state_q, state_d;

   logic [4:0]        rd_q;
   logic              rd_wen_q;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [2:0]        wb_sel_q;
   logic [ADDR_W-1:0] pc_q;
   logic [XLEN-1:0]   alu_q;
   logic [OFF_W-1:0]  off_q;

   logic [ADDR_W-1:0] in_addr;
   logic              in_is_mem;
   logic              in_misalign;
   logic [NB-1:0]     st_be;
   logic [XLEN-1:0]   st_wdata;
   logic [XLEN-1:0]   ld_data;

   assign in_ready  = (state_q == S_IDLE);
   assign in_addr   = ADDR_W'(in_alu_result);
   assign in_is_mem = in_mem_we | in_mem_re;

   lsu_align #(.XLEN(XLEN)) u_align (
      .st_size   (eff_size(in_funct3, XLEN)),
      .st_off    (in_alu_result[OFF_W-1:0]),
      .st_data   (in_store_data),
      .be        (st_be),
      .wdata     (st_wdata),
      .misalign  (in_misalign),
      .ld_funct3 (funct3_q),
      .ld_off    (off_q),
      .rdata     (mem_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_valid) state_d = (in_is_mem && !in_misalign) ? S_REQ : S_DONE;
         S_REQ:   if (mem_gnt) state_d = we_q ? S_DONE : S_RSP;
         S_RSP:   if (mem_rvalid) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q        <= '0;
         rd_wen_q    <= 1'b0;
         we_q        <= 1'b0;
         funct3_q    <= '0;
         wb_sel_q    <= '0;
         pc_q        <= '0;
         alu_q       <= '0;
         off_q       <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_rd_wen   <= 1'b0;
         wb_data     <= '0;
         wb_pc       <= '0;
         wb_misalign <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (state_q)
            S_IDLE: if (in_valid) begin
               rd_q     <= in_rd;
               rd_wen_q <= in_rd_wen;
               we_q     <= in_mem_we;
               funct3_q <= in_funct3;
               wb_sel_q <= in_wb_sel;
               pc_q     <= in_pc;
               alu_q    <= in_alu_result;
               off_q    <= in_alu_result[OFF_W-1:0];
               if (in_is_mem && !in_misalign) begin
                  mem_req   <= 1'b1;
                  mem_we    <= in_mem_we;
                  mem_addr  <= in_addr & ~ADDR_W'(NB - 1);
                  mem_wdata <= in_mem_we ? st_wdata : '0;
                  mem_be    <= st_be;
               end else begin
                  // Only a misaligned access can reach here as a memory op.
                  wb_valid    <= 1'b1;
                  wb_rd       <= in_rd;
                  wb_pc       <= in_pc;
                  wb_misalign <= in_is_mem;
                  wb_rd_wen   <= in_rd_wen & ~in_is_mem;
                  wb_data     <= (!in_is_mem && in_wb_sel == WB_ALU) ? in_alu_result : '0;
               end
            end
            S_REQ: if (mem_gnt) begin
               mem_req   <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               mem_be    <= '0;
               if (we_q) begin
                  wb_valid    <= 1'b1;
                  wb_rd       <= rd_q;
                  wb_rd_wen   <= rd_wen_q;
                  wb_pc       <= pc_q;
                  wb_misalign <= 1'b0;
                  wb_data     <= (wb_sel_q == WB_ALU) ? alu_q : '0;
               end
            end
            S_RSP: if (mem_rvalid) begin
               wb_valid    <= 1'b1;
               wb_rd       <= rd_q;
               wb_rd_wen   <= rd_wen_q;
               wb_pc       <= pc_q;
               wb_misalign <= 1'b0;
               wb_data     <= (wb_sel_q == WB_MEM) ? ld_data :
                              (wb_sel_q == WB_ALU) ? alu_q : '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 32-bit instance for most scenarios and a
// 64-bit instance for doubleword/word lanes.
module tb_mem_stage_lsu;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // 32-bit instance
   logic        in_valid, in_ready, in_rd_wen, in_mem_we, in_mem_re;
   logic [31:0] in_alu_result, in_store_data, in_pc;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3, in_wb_sel;
   logic        mem_req, mem_gnt, mem_we, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        wb_valid, wb_rd_wen, wb_misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, wb_pc;

   // 64-bit instance
   logic        d_in_valid, d_in_ready, d_in_rd_wen, d_in_mem_we, d_in_mem_re;
   logic [63:0] d_in_alu_result, d_in_store_data;
   logic [31:0] d_in_pc;
   logic [4:0]  d_in_rd;
   logic [2:0]  d_in_funct3, d_in_wb_sel;
   logic        d_mem_req, d_mem_gnt, d_mem_we, d_mem_rvalid;
   logic [31:0] d_mem_addr;
   logic [63:0] d_mem_wdata, d_mem_rdata;
   logic [7:0]  d_mem_be;
   logic        d_wb_valid, d_wb_rd_wen, d_wb_misalign;
   logic [4:0]  d_wb_rd;
   logic [63:0] d_wb_data;
   logic [31:0] d_wb_pc;

   mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_rd(in_rd), .in_rd_wen(in_rd_wen),
      .in_mem_we(in_mem_we), .in_mem_re(in_mem_re),
      .in_funct3(in_funct3), .in_wb_sel(in_wb_sel), .in_pc(in_pc),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_wen(wb_rd_wen),
      .wb_data(wb_data), .wb_pc(wb_pc), .wb_misalign(wb_misalign)
   );

   mem_stage_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .rst(rst),
      .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_alu_result(d_in_alu_result), .in_store_data(d_in_store_data),
      .in_rd(d_in_rd), .in_rd_wen(d_in_rd_wen),
      .in_mem_we(d_in_mem_we), .in_mem_re(d_in_mem_re),
      .in_funct3(d_in_funct3), .in_wb_sel(d_in_wb_sel), .in_pc(d_in_pc),
      .mem_req(d_mem_req), .mem_gnt(d_mem_gnt), .mem_we(d_mem_we),
      .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_be(d_mem_be),
      .mem_rvalid(d_mem_rvalid), .mem_rdata(d_mem_rdata),
      .wb_valid(d_wb_valid), .wb_rd(d_wb_rd), .wb_rd_wen(d_wb_rd_wen),
      .wb_data(d_wb_data), .wb_pc(d_wb_pc), .wb_misalign(d_wb_misalign)
   );

   task automatic put_op(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                         input logic we, input logic re, input logic [2:0] sel,
                         input logic [4:0] rd, input logic wen, input logic [31:0] pc);
      in_alu_result = alu; in_store_data = sd; in_funct3 = f3;
      in_mem_we = we; in_mem_re = re; in_wb_sel = sel;
      in_rd = rd; in_rd_wen = wen; in_pc = pc; in_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      tests++; if ({mem_addr, mem_be, wb_data} !== '0) begin fails++; $display("FAIL reset_outputs got %h exp 0", {mem_addr, mem_be, wb_data}); end
      tests++; if (d_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready64 got %b exp 1", d_in_ready); end
      rst = 1'b0;
   endtask

   task automatic test_alu_op();
      put_op(32'h1234, 32'h0, 3'b010, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1, 32'h100);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL alu_wb_valid got %b exp 1", wb_valid); end
      tests++; if (wb_data !== 32'h1234) begin fails++; $display("FAIL alu_wb_data got %h exp 00001234", wb_data); end
      tests++; if ({wb_rd, wb_rd_wen, wb_misalign} !== {5'd5, 1'b1, 1'b0}) begin fails++; $display("FAIL alu_wb_ctl got %b exp 0010110", {wb_rd, wb_rd_wen, wb_misalign}); end
      tests++; if (wb_pc !== 32'h100) begin fails++; $display("FAIL alu_wb_pc got %h exp 00000100", wb_pc); end
      tests++; if (mem_req !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL alu_req_ready got %b%b exp 00", mem_req, in_ready); end
      @(negedge clk);
      tests++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL alu_after got %b%b exp 01", wb_valid, in_ready); end
   endtask

   task automatic test_load_byte();
      logic [2:0]  f3 [2]  = '{3'b000, 3'b100};
      logic [31:0] exp [2] = '{32'hFFFF_FF80, 32'h0000_0080};
      for (int i = 0; i < 2; i++) begin
         put_op(32'h1003, 32'h0, f3[i], 1'b0, 1'b1, 3'b100, 5'd7, 1'b1, 32'h200);
         @(posedge clk); @(negedge clk);
         in_valid = 1'b0;
         tests++; if ({mem_req, mem_we} !== 2'b10) begin fails++; $display("FAIL lb_req got %b exp 10", {mem_req, mem_we}); end
         tests++; if (mem_addr !== 32'h1000) begin fails++; $display("FAIL lb_addr got %h exp 00001000", mem_addr); end
         tests++; if (mem_be !== 4'b1000) begin fails++; $display("FAIL lb_be got %b exp 1000", mem_be); end
         mem_gnt = 1'b1;
         @(posedge clk); @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FFFF;
         tests++; if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin fails++; $display("FAIL lb_rsp got %b%b exp 00", mem_req, wb_valid); end
         @(posedge clk); @(negedge clk);
         mem_rvalid = 1'b0;
         tests++; if (wb_valid !== 1'b1 || wb_data !== exp[i]) begin fails++; $display("FAIL lb_data[%0d] got %b/%h exp 1/%h", i, wb_valid, wb_data, exp[i]); end
         tests++; if (wb_rd_wen !== 1'b1 || wb_rd !== 5'd7) begin fails++; $display("FAIL lb_rd got %b/%0d exp 1/7", wb_rd_wen, wb_rd); end
         @(negedge clk);
      end
   endtask

   task automatic test_store_half();
      put_op(32'h2002, 32'h0000_ABCD, 3'b001, 1'b1, 1'b0, 3'b000, 5'd0, 1'b0, 32'h300);
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || wb_valid !== 1'b0) begin fails++; $display("FAIL sh_hold[%0d] got %b%b%b exp 110", c, mem_req, mem_we, wb_valid); end
         tests++; if (mem_be !== 4'b1100 || mem_addr !== 32'h2000) begin fails++; $display("FAIL sh_be_addr[%0d] got %b/%h exp 1100/00002000", c, mem_be, mem_addr); end
         tests++; if (mem_wdata !== 32'hABCD_ABCD) begin fails++; $display("FAIL sh_wdata[%0d] got %h exp abcdabcd", c, mem_wdata); end
         if (c < 2) @(posedge clk);
      end
      mem_gnt = 1'b1;
      @(posedge clk); @(negedge clk);
      mem_gnt = 1'b0;
      tests++; if (wb_valid !== 1'b1 || wb_rd_wen !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL sh_done got %b%b%b exp 100", wb_valid, wb_rd_wen, mem_req); end
      @(negedge clk);
   endtask

   task automatic test_misalign();
      logic [31:0] addr [2] = '{32'h3001, 32'h2001};
      logic [2:0]  f3   [2] = '{3'b010, 3'b001};
      logic        we   [2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         put_op(addr[i], 32'h5555, f3[i], we[i], ~we[i], 3'b100, 5'd9, 1'b1, 32'h400);
         @(posedge clk); @(negedge clk);
         in_valid = 1'b0;
         tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL mis_req[%0d] got %b exp 0", i, mem_req); end
         tests++; if ({wb_valid, wb_misalign, wb_rd_wen} !== 3'b110) begin fails++; $display("FAIL mis_flags[%0d] got %b exp 110", i, {wb_valid, wb_misalign, wb_rd_wen}); end
         tests++; if (wb_data !== 32'h0) begin fails++; $display("FAIL mis_data[%0d] got %h exp 0", i, wb_data); end
         @(negedge clk);
      end
   endtask

   task automatic test_load_late();
      // LH at offset 2, grant and response each one cycle late.
      put_op(32'h4006, 32'h0, 3'b001, 1'b0, 1'b1, 3'b100, 5'd3, 1'b1, 32'h500);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      tests++; if (wb_valid !== 1'b0 || mem_be !== 4'b1100) begin fails++; $display("FAIL late_c1 got %b/%b exp 0/1100", wb_valid, mem_be); end
      @(negedge clk);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      tests++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL late_c3 got %b%b exp 00", wb_valid, mem_req); end
      mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
      @(negedge clk);
      mem_rvalid = 1'b0;
      tests++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_8001) begin fails++; $display("FAIL late_c4 got %b/%h exp 1/ffff8001", wb_valid, wb_data); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      put_op(32'h5000, 32'h0, 3'b010, 1'b0, 1'b1, 3'b100, 5'd11, 1'b1, 32'h600);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++; if (in_ready !== 1'b1 || {mem_req, wb_valid} !== 2'b00) begin fails++; $display("FAIL rstmid_state got %b%b%b exp 100", in_ready, mem_req, wb_valid); end
      tests++; if ({wb_data, wb_rd, wb_pc} !== '0) begin fails++; $display("FAIL rstmid_wb got %h exp 0", {wb_data, wb_rd, wb_pc}); end
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      @(negedge clk);
      tests++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL rstmid_stray got %b%b%b exp 010", wb_valid, in_ready, mem_req); end
   endtask

   task automatic test_back_to_back();
      put_op(32'hA1, 32'h0, 3'b000, 1'b0, 1'b0, 3'b000, 5'd1, 1'b1, 32'h700);
      @(posedge clk); @(negedge clk);
      tests++; if (wb_data !== 32'hA1 || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_first got %h/%b exp a1/0", wb_data, in_ready); end
      in_alu_result = 32'hB2; in_pc = 32'h704;
      @(negedge clk);
      tests++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_gap got %b%b exp 01", wb_valid, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      tests++; if (wb_valid !== 1'b1 || wb_data !== 32'hB2 || wb_pc !== 32'h704) begin fails++; $display("FAIL b2b_second got %b/%h/%h exp 1/b2/704", wb_valid, wb_data, wb_pc); end
      @(negedge clk);
   endtask

   task automatic test_xlen64();
      logic [63:0] addr [2] = '{64'h8, 64'hC};
      logic [2:0]  f3   [2] = '{3'b011, 3'b010};
      logic [7:0]  be   [2] = '{8'hFF, 8'hF0};
      logic [63:0] exp  [2] = '{64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_DEAD_BEEF};
      for (int i = 0; i < 2; i++) begin
         d_in_alu_result = addr[i]; d_in_funct3 = f3[i]; d_in_mem_re = 1'b1;
         d_in_wb_sel = 3'b100; d_in_rd = 5'd12; d_in_rd_wen = 1'b1; d_in_valid = 1'b1;
         @(posedge clk); @(negedge clk);
         d_in_valid = 1'b0;
         tests++; if (d_mem_be !== be[i] || d_mem_addr !== 32'h8) begin fails++; $display("FAIL x64_be_addr[%0d] got %h/%h exp %h/00000008", i, d_mem_be, d_mem_addr, be[i]); end
         d_mem_gnt = 1'b1;
         @(negedge clk);
         d_mem_gnt = 1'b0; d_mem_rvalid = 1'b1; d_mem_rdata = 64'hDEAD_BEEF_0123_4567;
         @(negedge clk);
         d_mem_rvalid = 1'b0;
         tests++; if (d_wb_valid !== 1'b1 || d_wb_data !== exp[i]) begin fails++; $display("FAIL x64_data[%0d] got %b/%h exp 1/%h", i, d_wb_valid, d_wb_data, exp[i]); end
         @(negedge clk);
      end
   endtask

   initial begin
      in_valid = 0; in_alu_result = 0; in_store_data = 0; in_rd = 0; in_rd_wen = 0;
      in_mem_we = 0; in_mem_re = 0; in_funct3 = 0; in_wb_sel = 0; in_pc = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      d_in_valid = 0; d_in_alu_result = 0; d_in_store_data = 0; d_in_rd = 0; d_in_rd_wen = 0;
      d_in_mem_we = 0; d_in_mem_re = 0; d_in_funct3 = 0; d_in_wb_sel = 0; d_in_pc = 0;
      d_mem_gnt = 0; d_mem_rvalid = 0; d_mem_rdata = 0;
      @(negedge clk);
      test_reset();
      test_alu_op();
      test_load_byte();
      test_store_half();
      test_misalign();
      test_load_late();
      test_reset_mid();
      test_back_to_back();
      test_xlen64();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
